// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receive path with glitch filter, frame watchdog,
// make/break/extended decoding, Shift/Caps tracking and an event FIFO.
//
// Optional feature macro: PS2_KBD_ASCII_EN. When defined, evt_ascii carries a
// translation of the make code. When undefined, evt_ascii is tied to 00.
//
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   ps2_clk_async       raw PS/2 clock line
//   ps2_data_async      raw PS/2 data line
//   evt_valid/evt_ready event handshake (head of FIFO)
//   evt_scan/ext/brk    head scan code, E0 prefix flag, release flag
//   evt_ascii           head ASCII translation (00 when feature absent)
//   shift_o, caps_o     modifier state
//   err_frame           one-cycle pulse on a bad frame or a watchdog timeout
//   overflow            one-cycle pulse when an event is dropped (FIFO full)
//   fifo_level          number of events held
//
// Handshake: evt_valid is high whenever the FIFO holds an event and the head
// fields are stable while it stays high. The head is consumed on a cycle where
// evt_valid and evt_ready are both high. evt_ready with evt_valid low is ignored.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ps2_clk_async,
  input  logic                         ps2_data_async,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [7:0]                   evt_scan,
  output logic                         evt_ext,
  output logic                         evt_brk,
  output logic [7:0]                   evt_ascii,
  output logic                         shift_o,
  output logic                         caps_o,
  output logic                         err_frame,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);

  // ---------------- input synchroniser and clock filter ----------------
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_fall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else begin
      clk_s1  <= ps2_clk_async;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data_async;
      data_s2 <= data_s1;
      // Count consecutive samples that disagree with the filtered level; any
      // agreeing sample restarts the count, so short glitches never pass.
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Asserted in the cycle the filtered clock is about to drop.
  assign filt_fall = filt_clk && !clk_s2 && (filt_cnt == FILT_LAST);

  // ---------------- frame receiver and watchdog ----------------
  logic [3:0]    bit_cnt;
  logic [7:0]    sh;
  logic          start_bit, par_bit;
  logic [7:0]    rx_byte;
  logic          rx_rdy;
  logic [TW-1:0] wd_cnt;
  logic          frame_ok;

  // Evaluated when the stop bit is on data_s2.
  assign frame_ok = !start_bit && data_s2 && (^{sh, par_bit});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      sh        <= '0;
      start_bit <= 1'b0;
      par_bit   <= 1'b0;
      rx_byte   <= '0;
      rx_rdy    <= 1'b0;
      err_frame <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      rx_rdy    <= 1'b0;
      err_frame <= 1'b0;
      if (filt_fall) begin
        wd_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          start_bit <= data_s2;
          bit_cnt   <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          sh      <= {data_s2, sh[7:1]};  // LSB arrives first
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          par_bit <= data_s2;
          bit_cnt <= 4'd10;
        end else begin
          bit_cnt <= 4'd0;
          if (frame_ok) begin
            rx_byte <= sh;
            rx_rdy  <= 1'b1;
          end else begin
            err_frame <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (wd_cnt == WD_LAST) begin
          bit_cnt   <= 4'd0;
          wd_cnt    <= '0;
          err_frame <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + TW'(1);
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  // ---------------- decoder and modifier state ----------------
  logic       ext_flag, brk_flag;
  logic       lshift, rshift, caps, caps_held;
  logic       evt_push;
  logic [7:0] new_ascii;
  logic [17:0] new_evt;

  assign shift_o  = lshift | rshift;
  assign caps_o   = caps;
  assign evt_push = rx_rdy && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);

`ifdef PS2_KBD_ASCII_EN
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] sc,
                                               input logic shifted,
                                               input logic upper);
    logic [7:0] letter, digit, sym, other;
    letter = 8'h00; digit = 8'h00; sym = 8'h00; other = 8'h00;
    case (sc)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      8'h45: begin digit = 8'h30; sym = 8'h29; end
      8'h16: begin digit = 8'h31; sym = 8'h21; end
      8'h1E: begin digit = 8'h32; sym = 8'h40; end
      8'h26: begin digit = 8'h33; sym = 8'h23; end
      8'h25: begin digit = 8'h34; sym = 8'h24; end
      8'h2E: begin digit = 8'h35; sym = 8'h25; end
      8'h36: begin digit = 8'h36; sym = 8'h5E; end
      8'h3D: begin digit = 8'h37; sym = 8'h26; end
      8'h3E: begin digit = 8'h38; sym = 8'h2A; end
      8'h46: begin digit = 8'h39; sym = 8'h28; end
      8'h29: other = 8'h20;
      8'h5A: other = 8'h0D;
      8'h66: other = 8'h08;
      8'h0D: other = 8'h09;
      default: ;
    endcase
    if (letter != 8'h00) return upper ? (letter - 8'h20) : letter;
    if (digit != 8'h00)  return shifted ? sym : digit;
    return other;
  endfunction

  // Translation uses the modifier state before this byte's own update.
  assign new_ascii = (!ext_flag && !brk_flag)
                     ? scan_to_ascii(rx_byte, shift_o, shift_o ^ caps) : 8'h00;
`else
  assign new_ascii = 8'h00;
`endif

  assign new_evt = {rx_byte, ext_flag, brk_flag, new_ascii};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      caps      <= 1'b0;
      caps_held <= 1'b0;
    end else if (err_frame) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (rx_rdy) begin
      if (rx_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
        if (!ext_flag) begin
          case (rx_byte)
            8'h12: lshift <= !brk_flag;
            8'h59: rshift <= !brk_flag;
            8'h58: begin
              // caps_held blocks typematic repeats from toggling again.
              if (brk_flag) begin
                caps_held <= 1'b0;
              end else if (!caps_held) begin
                caps      <= !caps;
                caps_held <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- event FIFO (first-word fall-through) ----------------
  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, do_pop, do_wr;
  logic [17:0]   head;

  assign full   = (count == DEPTH_L);
  assign do_pop = evt_valid && evt_ready;
  assign do_wr  = evt_push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= evt_push && full && !do_pop;
      if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= new_evt;
  end

  assign head       = mem[rd_ptr];
  assign evt_valid  = (count != '0);
  assign fifo_level = count;
  // Gate the head so outputs read 0 while empty (storage is not reset).
  assign evt_scan   = evt_valid ? head[17:10] : 8'h00;
  assign evt_ext    = evt_valid ? head[9]     : 1'b0;
  assign evt_brk    = evt_valid ? head[8]     : 1'b0;
  assign evt_ascii  = evt_valid ? head[7:0]   : 8'h00;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: randomized bench for ps2_kbd_rx with a key-state reference
// model, an expected-event queue and a monitor that checks every pop.
module tb_ps2_kbd_rx;

  localparam int DEPTH = 4;
  localparam int FILT  = 4;
  localparam int TOUT  = 2000;
`ifdef PS2_KBD_ASCII_EN
  localparam bit ASCII_EN = 1'b1;
`else
  localparam bit ASCII_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_ext, evt_brk, shift_o, caps_o, err_frame, overflow;
  logic [7:0] evt_scan, evt_ascii;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FILT), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .ps2_clk_async(ps2_clk), .ps2_data_async(ps2_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_scan(evt_scan), .evt_ext(evt_ext), .evt_brk(evt_brk),
    .evt_ascii(evt_ascii), .shift_o(shift_o), .caps_o(caps_o),
    .err_frame(err_frame), .overflow(overflow), .fifo_level(fifo_level)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got cycle %0d required < 200000", cyc);
    $fatal(1, "global timeout");
  end

  // ---------------- bookkeeping ----------------
  int n_chk = 0, n_fail = 0;
  int err_seen = 0, ovf_seen = 0, exp_err = 0, exp_ovf = 0;
  int first_valid_cyc = -1;
  int last_low = 0;
  bit rand_rdy = 1'b0;
  logic [17:0] exp_q[$];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  bit m_ext, m_brk, m_caps;
  bit down [256];
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                8'h3D, 8'h3E, 8'h46};
  string sym_s = ")!@#$%^&*(";
  logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h21, 8'h24, 8'h12, 8'h59, 8'h58,
                            8'h29, 8'h5A, 8'h66, 8'h0D, 8'h16, 8'h1E, 8'h45,
                            8'h46, 8'h75, 8'h6B, 8'h74, 8'h05, 8'h14};

  function automatic bit m_shift();
    return down[8'h12] | down[8'h59];
  endfunction

  function automatic logic [7:0] ref_ascii(input logic [7:0] b, input bit sh,
                                           input bit cp);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 26; i++)
      if (b == letter_sc[i]) r = (sh ^ cp) ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (b == digit_sc[i]) r = sh ? sym_s[i] : 8'(8'h30 + i);
    if (b == 8'h29) r = 8'h20;
    if (b == 8'h5A) r = 8'h0D;
    if (b == 8'h66) r = 8'h08;
    if (b == 8'h0D) r = 8'h09;
    return ASCII_EN ? r : 8'h00;
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_caps = 0;
    for (int i = 0; i < 256; i++) down[i] = 0;
  endfunction

  // pop_at_push: the consumer pops in the same cycle this event is written.
  function automatic void model_byte(input logic [7:0] b, input bit pop_at_push);
    logic [7:0] asc;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      asc = (!m_ext && !m_brk) ? ref_ascii(b, m_shift(), m_caps) : 8'h00;
      if (exp_q.size() >= DEPTH && !pop_at_push) exp_ovf++;
      else exp_q.push_back({b, m_ext, m_brk, asc});
      if (!m_ext) begin
        if (b == 8'h58 && !m_brk && !down[8'h58]) m_caps = !m_caps;
        down[b] = !m_brk;
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (evt_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          check("evt_unexpected", {evt_scan, evt_ext, evt_brk, evt_ascii}, 64'hFFFFFFFF);
        end else begin
          check("event", {evt_scan, evt_ext, evt_brk, evt_ascii}, exp_q.pop_front());
        end
      end
      if (err_frame) err_seen++;
      if (overflow) ovf_seen++;
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      evt_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ps2_bit(input logic b, input bit pop_pulse);
    int gl;
    ps2_data = b;
    tick(2);
    if ($urandom_range(0, 3) == 0) begin
      gl = $urandom_range(1, 2);  // shorter than FILT: must be rejected
      ps2_clk = 1'b0;
      tick(gl);
      ps2_clk = 1'b1;
      tick(8 - gl);
    end else begin
      tick(8);
    end
    ps2_clk = 1'b0;
    last_low = cyc;
    if (pop_pulse) begin
      tick(2 + FILT);  // now just after the stop-bit sample edge N
      evt_ready = 1'b1;
      tick(1);         // edge N+1: push and pop together
      evt_ready = 1'b0;
      tick(20 - 3 - FILT);
    end else begin
      tick(20);
    end
    ps2_clk = 1'b1;
    tick(10);
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  task automatic send_byte(input logic [7:0] b, input int kind, input bit pop_pulse);
    logic par;
    if (kind == 0) model_byte(b, pop_pulse);
    else exp_err++;
    par = ~^b;
    if (kind == 1) par = ~par;
    ps2_bit(kind == 3, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(par, 1'b0);
    ps2_bit(kind != 2, pop_pulse);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (fifo_level != 0 && i < 3000) begin
      tick(1);
      i++;
    end
    check("drain_level", fifo_level, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst_n = 1'b0;
    tick(4);
    rst_n = 1'b1;
    tick(2);
    check("rst_valid", evt_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_scan", evt_scan, 0);
    check("rst_ascii", evt_ascii, 0);
    check("rst_shift", shift_o, 0);
    check("rst_caps", caps_o, 0);
    check("rst_err", err_frame, 0);
    check("rst_ovf", overflow, 0);

    // Single make: latency and level.
    send_byte(8'h1C, 0, 0);
    check("latency_valid", first_valid_cyc, last_low + 2 + FILT + 1);
    check("level_one", fifo_level, 1);
    evt_ready = 1'b1;
    drain();

    // Shift held around a letter.
    send_byte(8'h12, 0, 0);
    check("shift_held", shift_o, 1);
    send_byte(8'h1C, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h1C, 0, 0);
    check("shift_still", shift_o, 1);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h12, 0, 0);
    check("shift_released", shift_o, 0);
    drain();

    // Caps with typematic repeat.
    send_byte(8'h58, 0, 0);
    check("caps_on", caps_o, 1);
    send_byte(8'h58, 0, 0);
    check("caps_repeat", caps_o, 1);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h58, 0, 0);
    send_byte(8'h1C, 0, 0);
    check("caps_after", caps_o, 1);
    drain();

    // Extended make and break.
    send_byte(8'hE0, 0, 0);
    send_byte(8'h75, 0, 0);
    send_byte(8'hE0, 0, 0);
    send_byte(8'hF0, 0, 0);
    send_byte(8'h75, 0, 0);
    drain();

    // Bad parity, then a truncated frame left to time out.
    send_byte(8'h1C, 1, 0);
    tick(5);
    check("err_parity", err_seen, exp_err);
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    exp_err++;
    tick(TOUT + 100);
    check("err_timeout", err_seen, exp_err);
    check("err_no_event", fifo_level, 0);
    send_byte(8'h32, 0, 0);
    drain();

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) ps2_bit(1'($urandom_range(0, 1)), 1'b0);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    model_reset();
    tick(TOUT + 100);
    check("midrst_err", err_seen, exp_err);
    check("midrst_level", fifo_level, 0);
    check("midrst_caps", caps_o, 0);
    send_byte(8'h24, 0, 0);
    drain();

    // Overflow with the consumer stalled, then push+pop at full.
    evt_ready = 1'b0;
    send_byte(8'h1C, 0, 0);
    send_byte(8'h32, 0, 0);
    send_byte(8'h21, 0, 0);
    send_byte(8'h23, 0, 0);
    send_byte(8'h24, 0, 0);
    tick(5);
    check("ovf_level", fifo_level, DEPTH);
    check("ovf_pulses", ovf_seen, 1);
    send_byte(8'h2B, 0, 1);
    tick(5);
    check("pushpop_level", fifo_level, DEPTH);
    check("pushpop_no_ovf", ovf_seen, exp_ovf);
    evt_ready = 1'b1;
    drain();

    // Randomized traffic with a randomly stalling consumer.
    rand_rdy = 1'b1;
    repeat (40) begin
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'($urandom_range(0, 255)), $urandom_range(1, 3), 0);
      end else begin
        if ($urandom_range(0, 4) == 0) send_byte(8'hE0, 0, 0);
        if ($urandom_range(0, 2) == 0) send_byte(8'hF0, 0, 0);
        send_byte(pool[$urandom_range(0, 19)], 0, 0);
      end
      check("rand_shift", shift_o, m_shift());
      check("rand_caps", caps_o, m_caps);
    end
    rand_rdy = 1'b0;
    tick(2);
    evt_ready = 1'b1;
    drain();

    tick(5);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_err_count", err_seen, exp_err);
    check("final_ovf_count", ovf_seen, exp_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Parametrised successor to the single-channel PS/2 scan-code decoder: same PS/2 device-to-host receive path, generalised and hardened.
- Adds a clock-line glitch filter, a frame watchdog and full frame checking.
- Decodes make/break/extended prefixes into one event per key, tracks left/right Shift and Caps Lock, and queues events in a first-word-fall-through FIFO with a valid/ready handshake.
- Sits between the board PS/2 pins and the CPU keyboard MMIO register.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64
- FILTER_LEN, 8, cycles a synchronised PS/2 clock level must hold before the filtered clock changes; 1..255
- TIMEOUT_CYC, 50000, idle cycles mid-frame before the frame is abandoned (1 ms at 50 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- ps2_clk_async  in  1  raw PS/2 clock
- ps2_data_async  in  1  raw PS/2 data
- evt_valid  out  1  FIFO non-empty; head event presented
- evt_ready  in  1  consumer accepts head when evt_valid=1
- evt_scan  out  8  head scan code (prefix bytes removed)
- evt_ext  out  1  head event was E0-prefixed
- evt_brk  out  1  head event is a release
- evt_ascii  out  8  head ASCII (see Optional Feature)
- shift_o  out  1  left or right Shift currently held
- caps_o  out  1  Caps Lock state
- err_frame  out  1  one-cycle pulse: bad frame or timeout
- overflow  out  1  one-cycle pulse: event dropped, FIFO full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- One clock; reset is synchronous, active low (rst_n sampled on posedge clk). Reset values: every output 0, FIFO empty, bit counter 0, E0/F0 flags clear, shift/caps state clear. Synchroniser and filter flops reset to 1 (idle bus).
- Reset mid-frame abandons the frame; no event, no err_frame.
- Input stage: 2-flop synchroniser on both lines.
- Filtered clock takes the synchronised value only after FILTER_LEN consecutive equal samples. A filtered 1->0 transition samples the synchronised data.
- Receiver: bit counter 0..10 captures start, data[0..7] LSB first, odd parity, stop.
- Frame check on bit 10: start=0, stop=1, XOR of data and parity = 1.
- Failing frame: err_frame pulse; frame dropped; E0/F0 flags cleared.
- Watchdog: counter runs while the bit counter is not 0 and resets on each filtered falling edge. On reaching TIMEOUT_CYC: bit counter returns to 0, err_frame pulses once, flags clear.
- Decoder on each good byte:
  - E0 sets ext flag; no event.
  - F0 sets brk flag; no event.
  - Any other byte emits an event {scan, ext, brk, ascii}, then clears both flags.
  - E0 followed by F0 keeps both flags.
- Modifiers (non-extended only):
  - 12 sets/clears left shift on make/break; 59 does the same for right shift.
  - shift_o is the OR of the two.
  - 58 make toggles caps only if Caps was not already held; a held flag suppresses typematic repeats and clears on 58 break.
  - Modifier keys still emit events.
- Latency: the event is written to the FIFO on cycle N+1, where N is the stop-bit sample cycle. evt_valid and head fields are valid at N+2 when the FIFO was empty.
- FIFO: pop occurs when evt_valid & evt_ready; head fields are stable until popped. Pointers wrap modulo FIFO_DEPTH.
  - Push when full without a simultaneous pop: the new event is dropped, overflow pulses, and stored order is unchanged.
  - Push and pop in the same cycle when full: both take effect; level is unchanged.
  - evt_ready while empty is ignored.

Optional Feature:
- Macro PS2_KBD_ASCII_EN.
- Defined: evt_ascii is computed at push time from the make code, non-extended only:
  - Letters 1C..1A map to a-z, uppercase when shift_o XOR caps_o.
  - Digit row maps to 0-9, or !@#$%^&*() with shift_o only.
  - 29=20, 5A=0D, 66=08, 0D=09.
  - Other codes, all breaks and all extended events = 00.
- Undefined: the translation logic is absent and evt_ascii is tied to 00.

Test Plan:
- After reset, send frame data 1C parity 0 -> one event: scan 1C, ext 0, brk 0, ascii 61; evt_valid at N+2; fifo_level 1.
- Send 12, 1C, F0 1C, F0 12 -> events 12, 1C (ascii 41), 1C brk (ascii 00), 12 brk; shift_o 1 between, 0 after.
- Send 58, 58, F0 58, 1C -> caps_o goes 1 once (repeat ignored); last event ascii 41.
- Send E0 75 then E0 F0 75 -> events scan 75 ext 1 brk 0, then scan 75 ext 1 brk 1.
- Send 1C with parity 1; then 5 bits and idle TIMEOUT_CYC -> two err_frame pulses and no events; a following good 32 frame decodes normally.
- FIFO_DEPTH 4, evt_ready 0, send 5 makes -> level 4, one overflow pulse, first four returned in order. Pop and push in the same cycle at full -> level stays 4.
